// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared definitions for the multi-precision add/subtract sequencer.
//   state_t         : sequencer FSM states
//   DEF_N / DEF_W   : default slice width and operand width
//   calc_slices()   : number of slice cycles needed for a W-bit operation
//   width_ok()      : true when W is a whole multiple of N (checked at elaboration)
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 16;

  function automatic int calc_slices(input int w, input int n);
    return w / n;
  endfunction

  function automatic bit width_ok(input int w, input int n);
    return (n > 0) && (w >= n) && ((w % n) == 0);
  endfunction

endpackage

// File: rtl/fulladder.sv
// fulladder: N-bit ripple full adder slice.
//   a, b   : N-bit addends
//   c_in   : carry in
//   sum    : N-bit sum
//   c_out  : carry out of the top bit
module fulladder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/mp_adder_seq.sv
// mp_adder_seq: W-bit add/subtract computed N bits per cycle through one
// shared fulladder slice, carry chained between slices over SLICES cycles.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (op_a, op_b, op_cin, sub)
//   op_a, op_b           : W-bit operands
//   op_cin               : carry in for additions (ignored when sub=1)
//   sub                  : 0 = A+B+cin, 1 = A-B
//   out_valid / out_ready: result handshake
//   result               : W-bit sum or difference
//   c_out                : final carry (for subtraction 1 means no borrow)
//   ovf                  : signed overflow
//   busy                 : high while an operation is in RUN or DONE
module mp_adder_seq
  import mp_add_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         ovf,
  output logic         busy
);

  localparam int SLICES = calc_slices(W, N);
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLICES - 1);

  if (!width_ok(W, N)) begin : g_width_check
    $error("mp_adder_seq: W must be a non-zero multiple of N");
  end

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;
  logic             a_s;
  logic             b_s;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     slice_sum;
  logic             slice_cout;
  logic [W-1:0]     sum_top;
  logic             last_slice;

  fulladder #(.N(N)) u_slice (
    .a     (a_reg[N-1:0]),
    .b     (b_reg[N-1:0]),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // Each new slice sum enters at the top of result; after SLICES shifts the
  // first (least significant) slice has reached bit 0.
  assign sum_top    = W'(slice_sum) << (W - N);
  assign last_slice = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  // Subtraction is A + ~B + 1, so B is inverted at capture and the carry
  // seeded with 1. b_s is the sign of the effective (possibly inverted) B,
  // which makes the same overflow rule serve both operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      a_s    <= 1'b0;
      b_s    <= 1'b0;
      cnt    <= '0;
      result <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= op_a;
            b_reg <= sub ? ~op_b : op_b;
            carry <= sub ? 1'b1 : op_cin;
            a_s   <= op_a[W-1];
            b_s   <= sub ? ~op_b[W-1] : op_b[W-1];
            cnt   <= '0;
          end
        end
        RUN: begin
          result <= (result >> N) | sum_top;
          a_reg  <= a_reg >> N;
          b_reg  <= b_reg >> N;
          carry  <= slice_cout;
          cnt    <= cnt + CNT_W'(1);
          if (last_slice) begin
            c_out <= slice_cout;
            ovf   <= (a_s == b_s) && (slice_sum[N-1] != a_s);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_adder_seq.sv
// tb_mp_adder_seq: directed and randomized checks of mp_adder_seq against an
// arithmetic reference model (plain integer add/subtract and signed range test).
module tb_mp_adder_seq;

  localparam int N      = 4;
  localparam int W      = 16;
  localparam int SLICES = W / N;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] op_a      = '0;
  logic [W-1:0] op_b      = '0;
  logic         op_cin    = 1'b0;
  logic         sub       = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;
  logic         busy;

  int n_vec    = 0;
  int n_miscmp = 0;

  logic [W-1:0] exp_r;
  logic         exp_c;
  logic         exp_v;

  mp_adder_seq #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: unsigned arithmetic for result/carry, signed range for overflow.
  function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic s,
                                   output logic [W-1:0] r, output logic c,
                                   output logic v);
    int ua, ub, sa, sb, full, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      full = ua - ub;
      c    = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub + int'(cin);
      c    = (full >= (1 << W));
      sr   = sa + sb + int'(cin);
    end
    r = full[W-1:0];
    v = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic s);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    compare("in_ready_idle", 32'(in_ready), 32'd1);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    sub      = s;
    in_valid = 1'b1;
    refModel(a, b, cin, s, exp_r, exp_c, exp_v);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    op_cin   = 1'($urandom);
    sub      = 1'($urandom);
    compare("busy_run", 32'(busy), 32'd1);
    compare("in_ready_run", 32'(in_ready), 32'd0);
  endtask

  // Waits (bounded) for out_valid, checks latency and outputs, optionally consumes.
  task automatic checkOutput(input string tag, input bit consume);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    compare({tag, "_latency"}, 32'(lat), 32'(SLICES));
    compare({tag, "_result"}, 32'(result), 32'(exp_r));
    compare({tag, "_c_out"}, 32'(c_out), 32'(exp_c));
    compare({tag, "_ovf"}, 32'(ovf), 32'(exp_v));
    compare({tag, "_busy_done"}, 32'(busy), 32'd1);
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      compare({tag, "_out_valid_clr"}, 32'(out_valid), 32'd0);
      compare({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    compare("rst_in_ready", 32'(in_ready), 32'd1);
    compare("rst_out_valid", 32'(out_valid), 32'd0);
    compare("rst_busy", 32'(busy), 32'd0);
    compare("rst_result", 32'(result), 32'd0);
    compare("rst_c_out", 32'(c_out), 32'd0);
    compare("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    checkOutput("add_basic", 1'b1);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add_ripple", 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("add_ovf", 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    checkOutput("sub_ovf", 1'b1);
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    checkOutput("sub_borrow", 1'b1);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
    checkOutput("sub_cin_ignored", 1'b1);
    applyStimulus(16'h00FF, 16'h0000, 1'b1, 1'b0);
    checkOutput("add_cin", 1'b1);

    // Backpressure: output held, extra requests ignored
    applyStimulus(16'hA5A5, 16'h1111, 1'b1, 1'b0);
    checkOutput("bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      sub      = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      compare("bp_in_ready", 32'(in_ready), 32'd0);
      compare("bp_out_valid", 32'(out_valid), 32'd1);
      compare("bp_result", 32'(result), 32'(exp_r));
      compare("bp_c_out", 32'(c_out), 32'(exp_c));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    compare("bp_release_idle", 32'(in_ready), 32'd1);
    compare("bp_release_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h0102, 16'h0304, 1'b0, 1'b0);
    checkOutput("bp_next", 1'b1);

    // Reset in the middle of RUN (after two slices)
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    compare("midrst_in_ready", 32'(in_ready), 32'd1);
    compare("midrst_out_valid", 32'(out_valid), 32'd0);
    compare("midrst_busy", 32'(busy), 32'd0);
    compare("midrst_result", 32'(result), 32'd0);
    compare("midrst_c_out", 32'(c_out), 32'd0);
    compare("midrst_ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    compare("midrst_no_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    checkOutput("after_rst", 1'b1);

    // Randomized operations against the reference model
    for (int k = 0; k < 40; k++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      checkOutput("rand", 1'b1);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
